can_acf_multibank: RTL and testbench

//  Parametrised successor to the SJA1000 single/dual acceptance filter.
//  - Holds NUM_FILTERS independent ID/mask/control banks.
//  - Scans them sequentially, one bank per clock, once a received frame

---
 rtl/can_acf_multibank.sv | 188 ++++++++++++++++++
 tb/tb_can_acf_multibank.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/can_acf_multibank.sv
// Multi-bank CAN acceptance filter: NUM_FILTERS id/mask/ctrl banks scanned one per clock
// after each received header, reporting accept and the lowest matching bank.
module can_acf_multibank #(
  parameter int NUM_FILTERS    = 4,
  parameter int IDX_W          = 2,
  parameter bit ACCEPT_IF_NONE = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reset_mode,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [1:0]       cfg_sel,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  input  logic             hdr_valid,
  input  logic [28:0]      hdr_id,
  input  logic             hdr_ide,
  input  logic             hdr_rtr,
  output logic             busy,
  output logic             result_valid,
  output logic             accept,
  output logic [IDX_W-1:0] hit_idx,
  output logic [15:0]      match_count,
  output logic             overrun
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SCAN = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FILTERS - 1);

  logic [28:0] id_q   [NUM_FILTERS];
  logic [28:0] mask_q [NUM_FILTERS];
  logic [4:0]  ctrl_q [NUM_FILTERS];

  logic [1:0]       state_q;
  logic [IDX_W-1:0] scan_idx_q;
  logic [28:0]      hdr_id_q;
  logic             hdr_ide_q;
  logic             hdr_rtr_q;
  logic [31:0]      rdata_q;
  logic             result_valid_q;
  logic             accept_q;
  logic [IDX_W-1:0] hit_idx_q;
  logic [15:0]      match_count_q;
  logic             overrun_q;

  logic [31:0] rd_next;
  logic [28:0] cur_id;
  logic [28:0] cur_mask;
  logic [4:0]  cur_ctrl;
  logic [28:0] cmp_bits;
  logic        any_en;
  logic        bank_hit;
  logic        none_accept;
  logic        start;
  logic        unused_wdata;

  assign unused_wdata = ^cfg_wdata[31:29];

  // Out-of-range cfg_idx never equals any k below, so such writes fall through.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NUM_FILTERS; k++) begin
        id_q[k]   <= '0;
        mask_q[k] <= '1;
        ctrl_q[k] <= '0;
      end
    end else if (reset_mode && cfg_we) begin
      for (int unsigned k = 0; k < NUM_FILTERS; k++) begin
        if (cfg_idx == IDX_W'(k)) begin
          case (cfg_sel)
            2'd0:    id_q[k]   <= cfg_wdata[28:0];
            2'd1:    mask_q[k] <= cfg_wdata[28:0];
            2'd2:    ctrl_q[k] <= cfg_wdata[4:0];
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int unsigned k = 0; k < NUM_FILTERS; k++) begin
      if (cfg_idx == IDX_W'(k)) begin
        case (cfg_sel)
          2'd0:    rd_next = {3'b000, id_q[k]};
          2'd1:    rd_next = {3'b000, mask_q[k]};
          2'd2:    rd_next = {27'd0, ctrl_q[k]};
          default: rd_next = '0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rd_next;
  end

  always_comb begin
    cur_id   = '0;
    cur_mask = '0;
    cur_ctrl = '0;
    any_en   = 1'b0;
    for (int unsigned k = 0; k < NUM_FILTERS; k++) begin
      any_en = any_en | ctrl_q[k][0];
      if (scan_idx_q == IDX_W'(k)) begin
        cur_id   = id_q[k];
        cur_mask = mask_q[k];
        cur_ctrl = ctrl_q[k];
      end
    end
  end

  // Standard frames compare only the left-aligned 11-bit id; mask bit 1 = don't care.
  assign cmp_bits = hdr_ide_q ? 29'h1FFF_FFFF : {11'h7FF, 18'h0};
  assign bank_hit = cur_ctrl[0]
                 && (!cur_ctrl[2] || (cur_ctrl[1] == hdr_ide_q))
                 && (!cur_ctrl[4] || (cur_ctrl[3] == hdr_rtr_q))
                 && (((cur_id ^ hdr_id_q) & ~cur_mask & cmp_bits) == '0);
  assign none_accept = ACCEPT_IF_NONE && !any_en;
  assign start       = hdr_valid && !reset_mode;

  // A new header always restarts from bank 0, including in SCAN (abort) and DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      scan_idx_q     <= '0;
      hdr_id_q       <= '0;
      hdr_ide_q      <= 1'b0;
      hdr_rtr_q      <= 1'b0;
      result_valid_q <= 1'b0;
      accept_q       <= 1'b0;
      hit_idx_q      <= '0;
      match_count_q  <= '0;
      overrun_q      <= 1'b0;
    end else begin
      result_valid_q <= 1'b0;
      if (reset_mode) begin
        state_q   <= S_IDLE;
        accept_q  <= 1'b0;
        overrun_q <= 1'b0;
      end else if (start) begin
        hdr_id_q   <= hdr_id;
        hdr_ide_q  <= hdr_ide;
        hdr_rtr_q  <= hdr_rtr;
        scan_idx_q <= '0;
        state_q    <= S_SCAN;
        if (state_q != S_IDLE) overrun_q <= 1'b1;
      end else begin
        case (state_q)
          S_SCAN: begin
            if (bank_hit) begin
              hit_idx_q      <= scan_idx_q;
              accept_q       <= 1'b1;
              result_valid_q <= 1'b1;
              if (match_count_q != 16'hFFFF) match_count_q <= match_count_q + 16'd1;
              state_q        <= S_DONE;
            end else if (scan_idx_q == LAST_IDX) begin
              hit_idx_q      <= '0;
              accept_q       <= none_accept;
              result_valid_q <= 1'b1;
              if (none_accept && match_count_q != 16'hFFFF) match_count_q <= match_count_q + 16'd1;
              state_q        <= S_DONE;
            end else begin
              scan_idx_q <= scan_idx_q + IDX_W'(1);
            end
          end
          S_DONE:  state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cfg_rdata    = rdata_q;
  assign busy         = (state_q != S_IDLE);
  assign result_valid = result_valid_q;
  assign accept       = accept_q;
  assign hit_idx      = hit_idx_q;
  assign match_count  = match_count_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_can_acf_multibank.sv
// Scoreboard bench for can_acf_multibank: directed headers push expected results,
// a negedge monitor pops and checks accept/hit_idx/latency on every result_valid.
module tb_can_acf_multibank;

  logic        clk = 1'b0;
  logic        rst;
  logic        reset_mode;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [1:0]  cfg_sel;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic        hdr_valid;
  logic [28:0] hdr_id;
  logic        hdr_ide;
  logic        hdr_rtr;
  logic        busy;
  logic        result_valid;
  logic        accept;
  logic [1:0]  hit_idx;
  logic [15:0] match_count;
  logic        overrun;

  typedef struct {
    logic        acc;
    logic [1:0]  idx;
    int unsigned due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [28:0] EXT_ID = 29'h1ABC_DEF0;

  can_acf_multibank #(.NUM_FILTERS(4), .IDX_W(2), .ACCEPT_IF_NONE(1'b1)) dut (
    .clk(clk), .rst(rst), .reset_mode(reset_mode),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata),
    .cfg_rdata(cfg_rdata),
    .hdr_valid(hdr_valid), .hdr_id(hdr_id), .hdr_ide(hdr_ide), .hdr_rtr(hdr_rtr),
    .busy(busy), .result_valid(result_valid), .accept(accept), .hit_idx(hit_idx),
    .match_count(match_count), .overrun(overrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && result_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result cyc=%0d accept=%0b hit_idx=%0d", cyc, accept, hit_idx);
      end else begin
        mon_e = sb.pop_front();
        if (accept !== mon_e.acc || hit_idx !== mon_e.idx || cyc != mon_e.due) begin
          errors++;
          $display("FAIL result actual acc=%0b idx=%0d cyc=%0d required acc=%0b idx=%0d cyc=%0d",
                   accept, hit_idx, cyc, mon_e.acc, mon_e.idx, mon_e.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic [1:0] sel, input logic [31:0] data);
    cfg_we = 1'b1; cfg_idx = idx; cfg_sel = sel; cfg_wdata = data;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic rd_check(input string name, input logic [1:0] idx, input logic [1:0] sel,
                          input logic [31:0] req);
    cfg_idx = idx; cfg_sel = sel;
    @(negedge clk);
    check(name, cfg_rdata, req);
  endtask

  task automatic send(input logic [28:0] id, input logic ide, input logic rtr, input bit push,
                      input logic acc, input logic [1:0] idx, input int unsigned lat);
    exp_t x;
    hdr_id = id; hdr_ide = ide; hdr_rtr = rtr; hdr_valid = 1'b1;
    if (push) begin
      x.acc = acc; x.idx = idx; x.due = cyc + lat;
      sb.push_back(x);
    end
    @(negedge clk);
    hdr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; reset_mode = 1'b1; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_wdata = '0;
    hdr_valid = 1'b0; hdr_id = '0; hdr_ide = 1'b0; hdr_rtr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result_valid", {31'd0, result_valid}, 32'd0);
    check("rst_accept", {31'd0, accept}, 32'd0);
    check("rst_hit_idx", {30'd0, hit_idx}, 32'd0);
    check("rst_match_count", {16'd0, match_count}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    check("rst_cfg_rdata", cfg_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    rd_check("rst_mask0", 2'd0, 2'd1, 32'h1FFF_FFFF);
    rd_check("rst_id3", 2'd3, 2'd0, 32'd0);
    rd_check("rst_ctrl1", 2'd1, 2'd2, 32'd0);

    // No bank enabled: accept everything after a full scan
    reset_mode = 1'b0;
    @(negedge clk);
    send(29'h123, 1'b0, 1'b0, 1, 1'b1, 2'd0, 5);
    wait_idle();
    check("count_t1", {16'd0, match_count}, 32'd1);

    // Bank 2 standard-id filter with ide_care
    reset_mode = 1'b1;
    wr(2'd2, 2'd0, 32'hF694_0000);
    wr(2'd2, 2'd1, 32'h0003_FFFF);
    wr(2'd2, 2'd2, 32'hFFFF_FFE5);
    rd_check("rd_id2", 2'd2, 2'd0, 32'h1694_0000);
    rd_check("rd_ctrl2", 2'd2, 2'd2, 32'h0000_0005);
    rd_check("rd_sel3", 2'd2, 2'd3, 32'd0);
    reset_mode = 1'b0;
    @(negedge clk);
    send(29'h1694_0000, 1'b0, 1'b0, 1, 1'b1, 2'd2, 4);
    wait_idle();
    check("accept_held", {31'd0, accept}, 32'd1);
    send(29'h1690_0000, 1'b0, 1'b0, 1, 1'b0, 2'd0, 5);
    wait_idle();
    send(29'h1694_0000, 1'b1, 1'b0, 1, 1'b0, 2'd0, 5);
    wait_idle();
    check("reject_held", {31'd0, accept}, 32'd0);

    // Banks 1 and 3 both match an extended id
    reset_mode = 1'b1;
    wr(2'd1, 2'd0, {3'b000, EXT_ID});
    wr(2'd1, 2'd1, 32'd0);
    wr(2'd1, 2'd2, 32'd1);
    wr(2'd3, 2'd0, {3'b000, EXT_ID});
    wr(2'd3, 2'd1, 32'd0);
    wr(2'd3, 2'd2, 32'd1);
    reset_mode = 1'b0;
    @(negedge clk);
    send(EXT_ID, 1'b1, 1'b0, 1, 1'b1, 2'd1, 3);
    wait_idle();
    reset_mode = 1'b1;
    wr(2'd1, 2'd2, 32'h19);
    reset_mode = 1'b0;
    @(negedge clk);
    send(EXT_ID, 1'b1, 1'b0, 1, 1'b1, 2'd3, 5);
    wait_idle();
    send(EXT_ID, 1'b1, 1'b1, 1, 1'b1, 2'd1, 3);
    wait_idle();
    send(29'h1ABC_DEF1, 1'b1, 1'b0, 1, 1'b0, 2'd0, 5);
    wait_idle();
    check("count_t3", {16'd0, match_count}, 32'd5);

    // Restart during SCAN: only the second header reports
    check("overrun_clear", {31'd0, overrun}, 32'd0);
    send(EXT_ID, 1'b1, 1'b1, 0, 1'b0, 2'd0, 0);
    @(negedge clk);
    send(EXT_ID, 1'b1, 1'b0, 1, 1'b1, 2'd3, 5);
    wait_idle();
    check("overrun_scan", {31'd0, overrun}, 32'd1);
    reset_mode = 1'b1;
    @(negedge clk);
    reset_mode = 1'b0;
    @(negedge clk);
    check("overrun_rm_clear", {31'd0, overrun}, 32'd0);

    // New header in the DONE cycle: both results reported
    send(EXT_ID, 1'b1, 1'b1, 1, 1'b1, 2'd1, 3);
    @(negedge clk);
    @(negedge clk);
    send(EXT_ID, 1'b1, 1'b0, 1, 1'b1, 2'd3, 5);
    wait_idle();
    check("overrun_done", {31'd0, overrun}, 32'd1);
    check("count_t4", {16'd0, match_count}, 32'd8);

    // reset_mode mid-scan aborts without a result
    send(EXT_ID, 1'b1, 1'b0, 0, 1'b0, 2'd0, 0);
    @(negedge clk);
    check("busy_mid_scan", {31'd0, busy}, 32'd1);
    reset_mode = 1'b1;
    @(negedge clk);
    check("busy_rm", {31'd0, busy}, 32'd0);
    check("overrun_rm", {31'd0, overrun}, 32'd0);
    check("accept_rm", {31'd0, accept}, 32'd0);
    repeat (8) @(negedge clk);
    send(EXT_ID, 1'b1, 1'b1, 0, 1'b0, 2'd0, 0);
    check("hdr_ignored_rm", {31'd0, busy}, 32'd0);
    rd_check("id0_before", 2'd0, 2'd0, 32'd0);
    reset_mode = 1'b0;
    wr(2'd0, 2'd0, 32'h0ABC_DEF0);
    rd_check("id0_locked", 2'd0, 2'd0, 32'd0);
    check("count_t5", {16'd0, match_count}, 32'd8);

    // Saturation of the accepted-frame counter
    dut.match_count_q = 16'hFFFE;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      send(EXT_ID, 1'b1, 1'b1, 1, 1'b1, 2'd1, 3);
      wait_idle();
    end
    check("count_sat", {16'd0, match_count}, 32'h0000_FFFF);

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
